frame_sequencer: RTL and testbench

Per-frame scheduler for the game-logic datapath. On each qualified frame tick it runs four sub-blocks in a fixed order: collision detect, character movement, background scroll, sprite draw. Each sub-block gets the same four-phase enable/done handshake that characterMovement uses. The block sits between the VGA timing generator (frame_tick source) and the game-logic blocks, and is the only driver of their enables.

---
 rtl/game_pkg.sv | 35 +++
 rtl/frame_sequencer_if.sv | 21 ++
 rtl/tick_divider.sv | 27 ++
 rtl/frame_sequencer.sv | 113 +++++++++++
 tb/tb_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game-logic definitions: sequencer state encoding, stage indices and defaults.
package game_pkg;

  // Encoding doubles as the debug stage value: 0 in IDLE, 2*k+phase+1 otherwise.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    C_REQ = 4'd1,
    C_REL = 4'd2,
    M_REQ = 4'd3,
    M_REL = 4'd4,
    S_REQ = 4'd5,
    S_REL = 4'd6,
    D_REQ = 4'd7,
    D_REL = 4'd8
  } state_e;

  localparam int unsigned STG_COLLIDE = 0;
  localparam int unsigned STG_MOVE    = 1;
  localparam int unsigned STG_SCROLL  = 2;
  localparam int unsigned STG_DRAW    = 3;

  localparam int unsigned FRAME_DIV_DEFAULT = 2;

  // Only meaningful for non-IDLE states.
  function automatic logic [1:0] stage_idx(state_e s);
    logic [3:0] v;
    v = s - 4'd1;
    return v[2:1];
  endfunction

  function automatic logic is_req(state_e s);
    return s[0];
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Enable/done handshake bundle between the frame sequencer and the four game-logic blocks.
interface frame_sequencer_if;
  logic collide_en;
  logic move_en;
  logic scroll_en;
  logic draw_en;
  logic collide_done;
  logic move_done;
  logic scroll_done;
  logic draw_done;

  modport master (
    output collide_en, move_en, scroll_en, draw_en,
    input  collide_done, move_done, scroll_done, draw_done
  );

  modport slave (
    input  collide_en, move_en, scroll_en, draw_en,
    output collide_done, move_done, scroll_done, draw_done
  );
endinterface

// File: rtl/tick_divider.sv
// Counts frame ticks modulo FRAME_DIV; flags the tick that wraps the count to zero.
module tick_divider
  import game_pkg::*;
#(
  parameter int unsigned FRAME_DIV = FRAME_DIV_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic frame_tick,
  output logic qual_tick
);

  localparam logic [7:0] LAST = 8'(FRAME_DIV - 1);

  logic [7:0] cnt_q;

  assign qual_tick = frame_tick && (cnt_q == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (frame_tick) begin
      cnt_q <= qual_tick ? '0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler running collide, move, scroll, draw via four-phase handshakes.
// Optional per-stage watchdog enabled by defining FRAME_SEQ_WATCHDOG_EN.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int unsigned FRAME_DIV      = FRAME_DIV_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic             overrun_clr,
  frame_sequencer_if.master hs,
  output logic             busy,
  output logic [3:0]       stage,
  output logic             overrun,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_count
);

  logic       qual_tick;
  state_e     state_q, state_nxt, state_d;
  logic [3:0] done, en_d, en_q;
  logic       wd_fire, seq_done;

  tick_divider #(
    .FRAME_DIV(FRAME_DIV)
  ) u_tick_divider (
    .clock     (clock),
    .resetn    (resetn),
    .frame_tick(frame_tick),
    .qual_tick (qual_tick)
  );

  assign done[STG_COLLIDE] = hs.collide_done;
  assign done[STG_MOVE]    = hs.move_done;
  assign done[STG_SCROLL]  = hs.scroll_done;
  assign done[STG_DRAW]    = hs.draw_done;

  assign hs.collide_en = en_q[STG_COLLIDE];
  assign hs.move_en    = en_q[STG_MOVE];
  assign hs.scroll_en  = en_q[STG_SCROLL];
  assign hs.draw_en    = en_q[STG_DRAW];

  always_comb begin
    state_nxt = state_q;
    if (state_q == IDLE) begin
      if (qual_tick && !pause) state_nxt = C_REQ;
    end else if (is_req(state_q)) begin
      if (done[stage_idx(state_q)]) state_nxt = state_e'(state_q + 4'd1);
    end else if (!done[stage_idx(state_q)]) begin
      state_nxt = (state_q == D_REL) ? IDLE : state_e'(state_q + 4'd1);
    end
  end

  assign state_d  = wd_fire ? IDLE : state_nxt;
  assign seq_done = (state_q == D_REL) && (state_d == IDLE);

  always_comb begin
    en_d = '0;
    if (state_d != IDLE && is_req(state_d)) en_d[stage_idx(state_d)] = 1'b1;
  end

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // Fires only while stalled; a handshake completing on the limit cycle wins.
  assign wd_fire = (state_q != IDLE) && (state_nxt == state_q) &&
                   (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (state_d != state_q) ? '0 : wd_q + WD_W'(1);
      if (wd_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      en_q        <= '0;
      busy        <= 1'b0;
      stage       <= '0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      busy    <= (state_d != IDLE);
      stage   <= state_d;
      if (seq_done) frame_count <= frame_count + CNT_W'(1);
      if (qual_tick && state_q != IDLE) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: tick table, enable-order scoreboard, corner sequences.
module tb_frame_sequencer;
  import game_pkg::*;

  localparam int unsigned FDIV = 2;
`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int WD_PUSH = 1;
`else
  localparam int WD_PUSH = 4;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        busy, overrun, timeout_err;
  logic [3:0]  stage;
  logic [15:0] frame_count;

  frame_sequencer_if hs();

  frame_sequencer #(
    .FRAME_DIV     (FDIV),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .pause      (pause),
    .overrun_clr(overrun_clr),
    .hs         (hs),
    .busy       (busy),
    .stage      (stage),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Done responders: auto mode answers delay_c cycles after enable, drops 1 cycle after.
  int unsigned delay_c[4] = '{3, 3, 3, 3};
  int unsigned rcnt[4]    = '{0, 0, 0, 0};
  logic [3:0]  auto_done  = '0;
  logic [3:0]  man        = '0;
  logic [3:0]  man_done   = '0;
  logic [3:0]  en_v;

  assign en_v = {hs.draw_en, hs.scroll_en, hs.move_en, hs.collide_en};
  assign hs.collide_done = man[0] ? man_done[0] : auto_done[0];
  assign hs.move_done    = man[1] ? man_done[1] : auto_done[1];
  assign hs.scroll_done  = man[2] ? man_done[2] : auto_done[2];
  assign hs.draw_done    = man[3] ? man_done[3] : auto_done[3];

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (en_v[i]) begin
        if (rcnt[i] >= delay_c[i] - 1) auto_done[i] <= 1'b1;
        else rcnt[i] <= rcnt[i] + 1;
      end else begin
        rcnt[i]      <= 0;
        auto_done[i] <= 1'b0;
      end
    end
  end

  // Scoreboard: expected stage order pushed at the starting tick, popped on each enable rise.
  int         exp_q[$];
  logic [3:0] en_prev = '0;
  logic [3:0] rise;

  assign rise = en_v & ~en_prev;

  always @(negedge clock) begin
    en_prev <= en_v;
    if (rise != 4'b0) begin
      check("one_hot", $countones(en_v), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL enable_order: got rise %b, expected no enable", rise);
      end else begin
        check("enable_order", {28'b0, rise}, 32'(1) << exp_q.pop_front());
      end
    end
  end

  int div_m = 0;

  task automatic tick(input int n_push, input bit clr);
    bit qual, started, was_busy;
    @(negedge clock);
    was_busy = busy;
    qual     = (div_m == FDIV - 1);
    div_m    = qual ? 0 : div_m + 1;
    started  = qual && !pause && !was_busy;
    if (started) for (int k = 0; k < n_push; k++) exp_q.push_back(k);
    frame_tick  = 1'b1;
    overrun_clr = clr;
    @(negedge clock);
    frame_tick  = 1'b0;
    overrun_clr = 1'b0;
    if (!was_busy) check("start_busy", {31'b0, busy}, {31'b0, started});
    if (started) check("collide_first", {31'b0, hs.collide_en}, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clock);
    check("idle", {31'b0, busy}, 0);
  endtask

  task automatic wait_en(input int idx);
    int i;
    for (i = 0; i < 100 && !en_v[idx]; i++) @(negedge clock);
    check("enable_seen", {31'b0, en_v[idx]}, 1);
  endtask

  typedef struct {
    bit pause;
    int ticks;
    int exp_fc;
  } vec_t;

  vec_t tbl[6];
  int   cycles;

  initial begin
    tbl[0] = '{0, 1, 0};  // first tick only advances the divider
    tbl[1] = '{0, 1, 1};  // qualifying tick runs one update
    tbl[2] = '{1, 4, 1};  // two qualifying ticks discarded while paused
    tbl[3] = '{0, 2, 2};
    tbl[4] = '{0, 3, 3};
    tbl[5] = '{0, 1, 4};

    repeat (3) @(negedge clock);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_stage", {28'b0, stage}, 0);
    check("rst_en", {28'b0, en_v}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_timeout", {31'b0, timeout_err}, 0);
    check("rst_count", {16'b0, frame_count}, 0);
    resetn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      pause = tbl[v].pause;
      for (int t = 0; t < tbl[v].ticks; t++) begin
        tick(4, 1'b0);
        wait_idle();
      end
      repeat (3) @(negedge clock);
      check("tbl_count", {16'b0, frame_count}, tbl[v].exp_fc);
      check("tbl_stage", {28'b0, stage}, 0);
      check("tbl_overrun", {31'b0, overrun}, 0);
    end
    pause = 1'b0;

    // Overrun: ticks keep arriving while the draw stage is slow.
    delay_c[3] = 12;
    tick(4, 1'b0);
    tick(4, 1'b0);
    tick(4, 1'b0);
    tick(4, 1'b0);
    check("ovr_set", {31'b0, overrun}, 1);
    check("ovr_busy", {31'b0, busy}, 1);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("ovr_clr", {31'b0, overrun}, 0);
    tick(4, 1'b0);
    tick(4, 1'b1);
    check("ovr_set_wins", {31'b0, overrun}, 1);
    wait_idle();
    check("ovr_count", {16'b0, frame_count}, 5);
    check("ovr_sticky", {31'b0, overrun}, 1);
    overrun_clr = 1'b1;
    @(negedge clock);
    overrun_clr = 1'b0;
    check("ovr_clr2", {31'b0, overrun}, 0);
    delay_c[3] = 3;

    // Pre-asserted move_done: M_REQ lasts one clock.
    man[1]      = 1'b1;
    man_done[1] = 1'b1;
    tick(4, 1'b0);
    tick(4, 1'b0);
    wait_en(STG_MOVE);
    check("pre_mreq", {28'b0, stage}, 3);
    @(negedge clock);
    check("pre_en_drop", {31'b0, hs.move_en}, 0);
    check("pre_mrel", {28'b0, stage}, 4);
    repeat (3) @(negedge clock);
    check("pre_mrel_hold", {28'b0, stage}, 4);
    man_done[1] = 1'b0;
    @(negedge clock);
    check("pre_sreq", {28'b0, stage}, 5);
    man[1] = 1'b0;
    wait_idle();
    check("pre_count", {16'b0, frame_count}, 6);

    // Asynchronous reset in S_REQ.
    tick(4, 1'b0);
    tick(4, 1'b0);
    wait_en(STG_SCROLL);
    #2 resetn = 1'b0;
    #1;
    check("arst_scroll_en", {31'b0, hs.scroll_en}, 0);
    check("arst_stage", {28'b0, stage}, 0);
    check("arst_count", {16'b0, frame_count}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    exp_q.delete();
    div_m = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // Watchdog: collide_done stuck low.
    man[0]      = 1'b1;
    man_done[0] = 1'b0;
    tick(WD_PUSH, 1'b0);
    tick(WD_PUSH, 1'b0);
    cycles = 0;
    while (hs.collide_en && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
`ifdef FRAME_SEQ_WATCHDOG_EN
    check("wd_cycles", cycles, 16);
    check("wd_flag", {31'b0, timeout_err}, 1);
    check("wd_stage", {28'b0, stage}, 0);
    check("wd_count", {16'b0, frame_count}, 0);
    man[0] = 1'b0;
`else
    check("nowd_held", cycles, 40);
    check("nowd_flag", {31'b0, timeout_err}, 0);
    man[0] = 1'b0;
    wait_idle();
    check("nowd_count", {16'b0, frame_count}, 1);
`endif
    repeat (3) @(negedge clock);
    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
